arinc429_rx_fifo: RTL and testbench
===================================

# arinc429_rx_fifo

Parametrised ARINC 429 receive channel. It oversamples the differential A/B line pair on `digi_clk` and decodes the RZ bipolar symbols, without clocking on the data lines. It frames 32-bit words on inter-word gaps, optionally checks odd parity, and buffers good words in an internal show-ahead FIFO. One instance sits per ARINC input, between the line receivers and the FDAU read-out logic, replacing the fixed single-rate receive/RAM pair.

## Interface
Parameters:
- `CLK_PER_BIT`, default 8: `digi_clk` cycles per nominal ARINC bit period.
- `MIN_PULSE`, default 2: minimum HI/LO run, in samples, accepted as a bit.
- `GAP_SAMPLES`, default 24: consecutive NULL samples that end a word. Must be greater than `CLK_PER_BIT` and less than `4*CLK_PER_BIT`.
- `FIFO_DEPTH`, default 16: word FIFO depth. Must be a power of 2, at least 2.

Ports:
- `digi_clk`, in, 1: sampling clock.
- `d_rst`, in, 1: reset, asynchronous, active-high.
- `line_a`, in, 1: ARINC line A, asynchronous.
- `line_b`, in, 1: ARINC line B, asynchronous.
- `rd_en`, in, 1: pop the FIFO head.
- `rd_data`, out, 32: FIFO head word. Bit 0 is the first bit received (label LSB). Valid while `!empty`.
- `empty`, out, 1: FIFO empty.
- `full`, out, 1: FIFO full.
- `fill`, out, $clog2(FIFO_DEPTH)+1: words held.
- `overflow`, out, 1: sticky. Set when a good word is lost because the FIFO is full. Cleared only by `d_rst`.
- `rx_err`, out, 1: one-cycle error strobe.
- `err_code`, out, 2: cause of the error, valid with `rx_err`. 1 = framing, 2 = line fault, 3 = parity.

## Operation
- `line_a` and `line_b` each pass through a 2-flop synchroniser. The synchronised pair classifies every sample:
  - A=1, B=0: HI.
  - A=0, B=1: LO.
  - 0/0: NULL.
  - 1/1: FAULT.
- State machine:
  - **SYNC** (reset state): waits for `GAP_SAMPLES` consecutive NULL samples, then goes to IDLE. Any non-NULL sample restarts the count. No errors are reported in SYNC.
  - **IDLE**: `bit_cnt`=0. On HI or LO go to BIT with `pulse_cnt`=1 and the bit value latched.
  - **BIT**:
    - Same level: `pulse_cnt`++, saturating.
    - Opposite level: line fault.
    - NULL with `pulse_cnt`>=`MIN_PULSE`: shift the bit in (`buf <= {bit, buf[31:1]}`), `bit_cnt`++, go to NULLW with `null_cnt`=1.
    - NULL with `pulse_cnt`<`MIN_PULSE`: line fault.
  - **NULLW**:
    - NULL: `null_cnt`++.
    - HI/LO: go to BIT. If `bit_cnt`==32 this is a framing error (33rd bit).
    - `null_cnt` reaches `GAP_SAMPLES`: if `bit_cnt`==32 go to CHECK, else framing error and go to IDLE.
  - **CHECK** (1 cycle): the parity decision is made here, then the state returns to IDLE.
    - Good word, FIFO not full, or FIFO full with `rd_en`=1 in the same cycle: the word is written.
    - Good word, FIFO full, no pop: the word is dropped and `overflow` is set.
  - FAULT in IDLE, BIT or NULLW: line fault, go to SYNC.
  - Line fault in BIT: go to SYNC.
  - Framing error at the 33rd bit: go to SYNC.
- Error exits pulse `rx_err` for one cycle with the matching `err_code`. The partial word is discarded.
- FIFO behaviour:
  - Show-ahead: `rd_data` is the head word whenever `!empty`.
  - `rd_en` while empty is ignored.
  - A simultaneous write and pop leaves `fill` unchanged.
  - Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
- Counter widths: `pulse_cnt` and `null_cnt` are wide enough for `GAP_SAMPLES` and saturate. `bit_cnt` is 6 bits.

## Timing
- Values after `d_rst`:
  - `empty`=1, `full`=0, `fill`=0, `overflow`=0.
  - `rx_err`=0, `err_code`=0, `rd_data`=0.
  - State is SYNC and all counters are 0.
- Input latency: 2 cycles through the synchroniser.
- Word latency: the sample at which `null_cnt` hits `GAP_SAMPLES` is edge N. CHECK occupies cycle N+1. The FIFO write happens at edge N+2, and `empty` falls after that edge.
- Pop: the `rd_en` edge advances the head, and the new `rd_data`/`empty` appear after that same edge.
- Reset mid-word or mid-write: all state clears immediately. The word in flight is lost and `overflow` clears.

## Configuration
- `ARINC_PARITY_CHECK_EN` defined:
  - CHECK computes XOR of `buf[31:0]`.
  - A result of 0 (even parity) means the word is not written and `rx_err` pulses with `err_code`=3.
- `ARINC_PARITY_CHECK_EN` not defined:
  - Every 32-bit framed word is written, with bit 31 stored as received.
  - `err_code`=3 never occurs.

## Test plan
- Reset, then a 30-sample NULL, then word 0x8000_00A5 (odd parity) at 8 samples/bit with 4 HI/LO + 4 NULL per bit, followed by a 32-sample gap → `empty` falls 2 cycles after the gap count hits 24, and `rd_data`=0x8000_00A5.
- Word 0x0000_00A5 (even parity) → with `ARINC_PARITY_CHECK_EN`, `rx_err`=1 and `err_code`=3 for 1 cycle and `empty` stays 1. Without the macro, the word is stored.
- 31 bits then a gap → `rx_err`/`err_code`=1 and no write. The next valid word is received correctly.
- A/B both high for 1 sample mid-word, or a 1-sample HI pulse → `err_code`=2, return to SYNC. The following word is accepted only after a 24-sample NULL.
- Write 17 words without `rd_en` (`FIFO_DEPTH`=16) → `full`=1, `fill`=16, and `overflow` is set on the 17th. Pops return words 1..16 in order. Then drive `rd_en` while full as the CHECK of a new word happens → `fill` stays 16 and no additional overflow is recorded.
- Assert `d_rst` in the middle of bit 12 → all outputs return to reset values immediately. A word sent after a 24-sample gap decodes correctly.

Source files
------------

// File: rtl/arinc429_rx_fifo.sv
// ---------------------------------------------------------------------------
// arinc429_rx_fifo
// ARINC 429 receive channel. Oversamples the A/B line pair on digi_clk,
// decodes RZ bipolar bits, frames 32-bit words on inter-word NULL gaps and
// buffers good words in a show-ahead FIFO.
//
// Optional feature macro: ARINC_PARITY_CHECK_EN
//   defined   : words with even parity are rejected (err_code 3)
//   undefined : every framed 32-bit word is stored as received
//
// Ports:
//   digi_clk  in   sampling clock
//   d_rst     in   asynchronous active-high reset
//   line_a    in   ARINC line A (asynchronous)
//   line_b    in   ARINC line B (asynchronous)
//   rd_en     in   pop FIFO head
//   rd_data   out  FIFO head word, bit 0 = first bit received
//   empty     out  FIFO empty
//   full      out  FIFO full
//   fill      out  words held
//   overflow  out  sticky: good word dropped on full FIFO
//   rx_err    out  one-cycle error strobe
//   err_code  out  1 = framing, 2 = line fault, 3 = parity
// ---------------------------------------------------------------------------
module arinc429_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 8,
  parameter int unsigned MIN_PULSE   = 2,
  parameter int unsigned GAP_SAMPLES = 24,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          digi_clk,
  input  logic                          d_rst,
  input  logic                          line_a,
  input  logic                          line_b,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          rx_err,
  output logic [1:0]                    err_code
);

  // Run counters must hold the gap length; a bit run never exceeds a bit period.
  localparam int unsigned CNT_MAX = (GAP_SAMPLES > CLK_PER_BIT) ? GAP_SAMPLES : CLK_PER_BIT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FW      = AW + 1;

  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_LINE  = 2'd2;
`ifdef ARINC_PARITY_CHECK_EN
  localparam logic [1:0] ERR_PARITY = 2'd3;
`endif

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_BIT,
    ST_NULLW,
    ST_CHECK
  } state_t;

  // Two-flop synchronisers for the asynchronous line pair
  logic a_s1, a_s2, b_s1, b_s2;

  always_ff @(posedge digi_clk or posedge d_rst) begin
    if (d_rst) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= line_a;
      a_s2 <= a_s1;
      b_s1 <= line_b;
      b_s2 <= b_s1;
    end
  end

  // Sample classification
  logic smp_hi, smp_lo, smp_null, smp_fault, smp_level;

  always_comb begin
    smp_hi    = a_s2 & ~b_s2;
    smp_lo    = ~a_s2 & b_s2;
    smp_null  = ~a_s2 & ~b_s2;
    smp_fault = a_s2 & b_s2;
    smp_level = smp_hi | smp_lo;
  end

  state_t          state;
  logic [CW-1:0]   pulse_cnt;
  logic [CW-1:0]   null_cnt;
  logic [5:0]      bit_cnt;
  logic            bit_val;
  logic [31:0]     shift_buf;
  logic            word_good;
  logic            wr_en;
  logic            rd_fire;

`ifdef ARINC_PARITY_CHECK_EN
  assign word_good = ^shift_buf;
`else
  assign word_good = 1'b1;
`endif

  // A full FIFO still accepts a word when the head is popped in the same cycle
  assign wr_en   = (state == ST_CHECK) && word_good && (!full || rd_en);
  assign rd_fire = rd_en && !empty;

  // Receive state machine: bit decode, word framing, error reporting
  always_ff @(posedge digi_clk or posedge d_rst) begin
    if (d_rst) begin
      state     <= ST_SYNC;
      pulse_cnt <= '0;
      null_cnt  <= '0;
      bit_cnt   <= '0;
      bit_val   <= 1'b0;
      shift_buf <= '0;
      overflow  <= 1'b0;
      rx_err    <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      rx_err   <= 1'b0;
      err_code <= 2'd0;
      case (state)
        ST_SYNC: begin
          bit_cnt   <= '0;
          pulse_cnt <= '0;
          if (smp_null) begin
            if (null_cnt == CW'(GAP_SAMPLES - 1)) begin
              state    <= ST_IDLE;
              null_cnt <= '0;
            end else begin
              null_cnt <= null_cnt + CW'(1);
            end
          end else begin
            null_cnt <= '0;
          end
        end

        ST_IDLE: begin
          bit_cnt  <= '0;
          null_cnt <= '0;
          if (smp_fault) begin
            state    <= ST_SYNC;
            rx_err   <= 1'b1;
            err_code <= ERR_LINE;
          end else if (smp_level) begin
            state     <= ST_BIT;
            pulse_cnt <= CW'(1);
            bit_val   <= smp_hi;
          end
        end

        ST_BIT: begin
          if (smp_fault || (smp_level && (smp_hi != bit_val))) begin
            state    <= ST_SYNC;
            null_cnt <= '0;
            rx_err   <= 1'b1;
            err_code <= ERR_LINE;
          end else if (smp_level) begin
            if (pulse_cnt != CW'(CNT_MAX))
              pulse_cnt <= pulse_cnt + CW'(1);
          end else if (pulse_cnt >= CW'(MIN_PULSE)) begin
            shift_buf <= {bit_val, shift_buf[31:1]};
            bit_cnt   <= bit_cnt + 6'd1;
            state     <= ST_NULLW;
            null_cnt  <= CW'(1);
          end else begin
            // Runt pulse
            state    <= ST_SYNC;
            null_cnt <= '0;
            rx_err   <= 1'b1;
            err_code <= ERR_LINE;
          end
        end

        ST_NULLW: begin
          if (null_cnt == CW'(GAP_SAMPLES)) begin
            if (bit_cnt == 6'd32) begin
              state <= ST_CHECK;
            end else begin
              state    <= ST_IDLE;
              rx_err   <= 1'b1;
              err_code <= ERR_FRAME;
            end
          end else if (smp_fault) begin
            state    <= ST_SYNC;
            null_cnt <= '0;
            rx_err   <= 1'b1;
            err_code <= ERR_LINE;
          end else if (smp_level) begin
            if (bit_cnt == 6'd32) begin
              // 33rd bit: word boundary lost, resynchronise
              state    <= ST_SYNC;
              null_cnt <= '0;
              rx_err   <= 1'b1;
              err_code <= ERR_FRAME;
            end else begin
              state     <= ST_BIT;
              pulse_cnt <= CW'(1);
              bit_val   <= smp_hi;
            end
          end else if (null_cnt != CW'(CNT_MAX)) begin
            null_cnt <= null_cnt + CW'(1);
          end
        end

        ST_CHECK: begin
          state    <= ST_IDLE;
          bit_cnt  <= '0;
          null_cnt <= '0;
`ifdef ARINC_PARITY_CHECK_EN
          if (!word_good) begin
            rx_err   <= 1'b1;
            err_code <= ERR_PARITY;
          end
`endif
          if (word_good && full && !rd_en)
            overflow <= 1'b1;
        end

        default: begin
          state    <= ST_SYNC;
          null_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO storage and show-ahead head register
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [FW-1:0] fill_nxt;
  logic [31:0]   head_nxt;

  always_comb begin
    rd_ptr_nxt = rd_fire ? (rd_ptr + AW'(1)) : rd_ptr;
    fill_nxt   = fill + FW'(wr_en) - FW'(rd_fire);
    // The new head is the incoming word only when it lands in the head slot
    if (wr_en && (rd_ptr_nxt == wr_ptr))
      head_nxt = shift_buf;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge digi_clk) begin
    if (wr_en)
      mem[wr_ptr] <= shift_buf;
  end

  always_ff @(posedge digi_clk or posedge d_rst) begin
    if (d_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill_nxt;
      empty  <= (fill_nxt == '0);
      full   <= (fill_nxt == FW'(FIFO_DEPTH));
      if (fill_nxt != '0)
        rd_data <= head_nxt;
    end
  end

endmodule

// File: tb/tb_arinc429_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_arinc429_rx_fifo
// Directed bench for arinc429_rx_fifo: word reception and latency, parity
// handling, framing and line faults, FIFO full/overflow/pop ordering and
// asynchronous reset mid-word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arinc429_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic        digi_clk;
  logic        d_rst;
  logic        line_a;
  logic        line_b;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  fill;
  logic        overflow;
  logic        rx_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [1:0] last_code = 2'd0;

  arinc429_rx_fifo #(
    .CLK_PER_BIT (8),
    .MIN_PULSE   (2),
    .GAP_SAMPLES (24),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .digi_clk (digi_clk),
    .d_rst    (d_rst),
    .line_a   (line_a),
    .line_b   (line_b),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .fill     (fill),
    .overflow (overflow),
    .rx_err   (rx_err),
    .err_code (err_code)
  );

  initial digi_clk = 1'b0;
  always #5 digi_clk = ~digi_clk;

  // Error strobe monitor, sampled mid-cycle
  always @(negedge digi_clk) begin
    if (rx_err) begin
      err_seen  = err_seen + 1;
      last_code = err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample: drive lines, let one rising edge pass, return 1ns after it
  task automatic drv(input logic a, input logic b, input logic rd);
    line_a = a;
    line_b = b;
    rd_en  = rd;
    @(posedge digi_clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic v);
    repeat (4) drv(v, ~v, 1'b0);
    repeat (4) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic pop();
    drv(1'b0, 1'b0, 1'b1);
  endtask

  // Distinct words with odd overall parity
  function automatic logic [31:0] mkword(input int i);
    logic [31:0] d;
    d = 32'h0103_0507 * 32'(i) + 32'h00A0_0000;
    return {~^d[30:0], d[30:0]};
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] exp_w;
    logic        b12;

    d_rst  = 1'b1;
    line_a = 1'b0;
    line_b = 1'b0;
    rd_en  = 1'b0;
    repeat (3) @(posedge digi_clk);
    #1;
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_fill",     32'(fill),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rx_err",   32'(rx_err),   32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_rd_data",  rd_data,       32'd0);
    d_rst = 1'b0;

    // Basic word and latency: 27 NULLs after the last bit still empty, 28th shows it
    gap(30);
    send_bits(32'h8000_00A5, 32);
    gap(23);
    check("lat_empty_before", 32'(empty), 32'd1);
    gap(1);
    check("lat_empty_after", 32'(empty), 32'd0);
    check("lat_rd_data", rd_data, 32'h8000_00A5);
    check("lat_fill", 32'(fill), 32'd1);
    gap(8);
    pop();
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_fill", 32'(fill), 32'd0);

    // Even-parity word
    send_bits(32'h0000_00A5, 32);
    gap(32);
`ifdef ARINC_PARITY_CHECK_EN
    exp_err++;
    check("par_err_cnt", 32'(err_seen), 32'(exp_err));
    check("par_code", 32'(last_code), 32'd3);
    check("par_empty", 32'(empty), 32'd1);
`else
    check("nopar_err_cnt", 32'(err_seen), 32'(exp_err));
    check("nopar_empty", 32'(empty), 32'd0);
    check("nopar_data", rd_data, 32'h0000_00A5);
    pop();
`endif

    // Short word: framing error, then a good word
    send_bits(32'hFFFF_FFFF, 31);
    gap(32);
    exp_err++;
    check("frm_err_cnt", 32'(err_seen), 32'(exp_err));
    check("frm_code", 32'(last_code), 32'd1);
    check("frm_empty", 32'(empty), 32'd1);
    send_bits(32'h1234_5678, 32);
    gap(32);
    check("frm_next_data", rd_data, 32'h1234_5678);
    pop();

    // A/B both high mid-word: line fault, remainder ignored while resyncing
    w = 32'h0F0F_0F0E;
    send_bits(w, 10);
    drv(1'b1, 1'b1, 1'b0);
    for (int i = 10; i < 32; i++) send_bit(w[i]);
    gap(32);
    exp_err++;
    check("flt_err_cnt", 32'(err_seen), 32'(exp_err));
    check("flt_code", 32'(last_code), 32'd2);
    check("flt_empty", 32'(empty), 32'd1);
    send_bits(w, 32);
    gap(32);
    check("flt_next_data", rd_data, w);
    pop();

    // Runt one-sample HI pulse
    send_bits(32'h0000_0155, 5);
    drv(1'b1, 1'b0, 1'b0);
    gap(32);
    exp_err++;
    check("runt_err_cnt", 32'(err_seen), 32'(exp_err));
    check("runt_code", 32'(last_code), 32'd2);
    send_bits(32'h8000_00A5, 32);
    gap(32);
    check("runt_next_data", rd_data, 32'h8000_00A5);
    pop();
    check("runt_empty", 32'(empty), 32'd1);

    // Fill to full, overflow on the 17th
    for (int i = 1; i <= 16; i++) begin
      send_bits(mkword(i), 32);
      gap(32);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_fill", 32'(fill), 32'd16);
    check("full_no_ovf", 32'(overflow), 32'd0);
    send_bits(mkword(17), 32);
    gap(32);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_fill", 32'(fill), 32'd16);
    // Pop on the write edge of word 18: head (word 1) leaves, word 18 enters
    send_bits(mkword(18), 32);
    gap(23);
    drv(1'b0, 1'b0, 1'b1);
    check("popwr_fill", 32'(fill), 32'd16);
    check("popwr_full", 32'(full), 32'd1);
    check("popwr_head", rd_data, mkword(2));
    gap(8);
    check("popwr_fill_hold", 32'(fill), 32'd16);
    for (int k = 2; k <= 17; k++) begin
      exp_w = (k == 17) ? mkword(18) : mkword(k);
      check($sformatf("order_%0d", k), rd_data, exp_w);
      pop();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_fill", 32'(fill), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of bit 12 with a word buffered
    send_bits(mkword(20), 32);
    gap(32);
    check("pre_rst_fill", 32'(fill), 32'd1);
    w   = mkword(21);
    b12 = w[11];
    send_bits(w, 11);
    drv(b12, ~b12, 1'b0);
    drv(b12, ~b12, 1'b0);
    d_rst = 1'b1;
    #1;
    check("mid_rst_empty",    32'(empty),    32'd1);
    check("mid_rst_fill",     32'(fill),     32'd0);
    check("mid_rst_full",     32'(full),     32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_rd_data",  rd_data,       32'd0);
    repeat (2) @(posedge digi_clk);
    line_a = 1'b0;
    line_b = 1'b0;
    #1;
    d_rst = 1'b0;
    gap(30);
    send_bits(mkword(22), 32);
    gap(32);
    check("post_rst_data", rd_data, mkword(22));
    check("post_rst_fill", 32'(fill), 32'd1);
    check("post_rst_err_cnt", 32'(err_seen), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
